adaptive_thresh_mean: RTL and testbench

//  Downstream of the 7x7 mean stage: adaptive binarisation (mean-C, binary). Stores the raw gray

---
 rtl/img_pkg.sv | 25 ++
 rtl/adapt_ring_linebuf.sv | 42 ++++
 rtl/adaptive_thresh_mean.sv | 162 ++++++++++++++++
 tb/tb_adaptive_thresh_mean.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared image-pipeline constants, types and width helper
// Contents: default frame geometry, pixel/coordinate widths, PIX_MAX,
//           COL_W() index-width helper, mean_req_t (one mean-stage request).
package img_pkg;

    localparam int IMAGE_WIDTH_DEF  = 320;
    localparam int IMAGE_HEIGHT_DEF = 240;
    localparam int PIX_W            = 8;
    localparam int COORD_W          = 32;

    localparam logic [PIX_W-1:0] PIX_MAX = 8'd255;

    // Bits needed to index n entries; never less than 1 so n=1 still yields a legal vector.
    function automatic int COL_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One request from the mean stage, carried through the read pipeline.
    typedef struct packed {
        logic [PIX_W-1:0]   mean;
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
    } mean_req_t;

endpackage

// File: rtl/adapt_ring_linebuf.sv
// rtl/adapt_ring_linebuf.sv - ring of raw-pixel line buffers, 1 write + 1 registered read port
// Ports:
//   clk                 clock
//   wr_en               write strobe
//   wr_row_sel, wr_col  write address (ring row, column)
//   wr_data             pixel to store
//   rd_en               read strobe
//   rd_row_sel, rd_col  read address (ring row, column)
//   rd_data             registered read data, valid the cycle after rd_en
module adapt_ring_linebuf
    import img_pkg::*;
#(
    parameter int RING_ROWS   = 8,
    parameter int IMAGE_WIDTH = IMAGE_WIDTH_DEF,
    localparam int RW         = COL_W(RING_ROWS),
    localparam int CW         = COL_W(IMAGE_WIDTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [RW-1:0]    wr_row_sel,
    input  logic [CW-1:0]    wr_col,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic [RW-1:0]    rd_row_sel,
    input  logic [CW-1:0]    rd_col,
    output logic [PIX_W-1:0] rd_data
);

    logic [PIX_W-1:0] mem [RING_ROWS][IMAGE_WIDTH];

    // Both ports live in one clocked block with non-blocking updates, so a read that hits
    // the address being written this cycle returns the previous contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_row_sel][wr_col] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_row_sel][rd_col];
        end
    end

endmodule

// File: rtl/adaptive_thresh_mean.sv
// rtl/adaptive_thresh_mean.sv - mean-C adaptive binarisation with per-frame foreground count
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   gray_valid, gray            raw pixel stream (raster order) written into the ring
//   mean_valid, mean_in         7x7 mean at centre (mean_row, mean_col)
//   bin_valid, bin_out          binary pixel (0/255), two cycles after mean_valid
//   bin_row, bin_col            coordinates of bin_out
//   fg_count, fg_count_valid    foreground count of the last completed frame, update pulse
//   overrun                     sticky: a mean referenced a ring row already overwritten
module adaptive_thresh_mean
    import img_pkg::*;
#(
    parameter int               IMAGE_WIDTH  = IMAGE_WIDTH_DEF,
    parameter int               IMAGE_HEIGHT = IMAGE_HEIGHT_DEF,
    parameter int               RING_ROWS    = 8,
    parameter logic [PIX_W-1:0] C_OFFSET     = 8'd5,
    parameter bit               INVERT       = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               gray_valid,
    input  logic [PIX_W-1:0]   gray,
    input  logic               mean_valid,
    input  logic [PIX_W-1:0]   mean_in,
    input  logic [COORD_W-1:0] mean_row,
    input  logic [COORD_W-1:0] mean_col,
    output logic               bin_valid,
    output logic [PIX_W-1:0]   bin_out,
    output logic [COORD_W-1:0] bin_row,
    output logic [COORD_W-1:0] bin_col,
    output logic [COORD_W-1:0] fg_count,
    output logic               fg_count_valid,
    output logic               overrun
);

    localparam int RW = COL_W(RING_ROWS);
    localparam int CW = COL_W(IMAGE_WIDTH);

    localparam logic [CW-1:0]      LAST_COL = CW'(IMAGE_WIDTH - 1);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMAGE_HEIGHT - 1);
    localparam logic [COORD_W-1:0] HEIGHT   = COORD_W'(IMAGE_HEIGHT);
    localparam logic [COORD_W-1:0] RING     = COORD_W'(RING_ROWS);
    // The last centre the 7x7 mean stage produces in a frame closes the frame count.
    localparam logic [COORD_W-1:0] END_ROW  = COORD_W'(IMAGE_HEIGHT - 4);
    localparam logic [COORD_W-1:0] END_COL  = COORD_W'(IMAGE_WIDTH - 4);

    // ---------------- write side ----------------
    logic [CW-1:0]      wr_col;
    logic [COORD_W-1:0] wr_row;
    logic               wr_en;

    assign wr_en = gray_valid && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_col <= '0;
            wr_row <= '0;
        end else if (gray_valid) begin
            if (wr_col == LAST_COL) begin
                wr_col <= '0;
                wr_row <= (wr_row == LAST_ROW) ? '0 : wr_row + 1'b1;
            end else begin
                wr_col <= wr_col + 1'b1;
            end
        end
    end

    // ---------------- ring storage ----------------
    logic [PIX_W-1:0] rd_data;

    adapt_ring_linebuf #(
        .RING_ROWS   (RING_ROWS),
        .IMAGE_WIDTH (IMAGE_WIDTH)
    ) u_ring (
        .clk        (clk),
        .wr_en      (wr_en),
        .wr_row_sel (wr_row[RW-1:0]),
        .wr_col     (wr_col),
        .wr_data    (gray),
        .rd_en      (mean_valid),
        .rd_row_sel (mean_row[RW-1:0]),
        .rd_col     (mean_col[CW-1:0]),
        .rd_data    (rd_data)
    );

    // ---------------- overrun detection ----------------
    // Rows the writer has advanced past the requested centre row, modulo frame height.
    // Once that reaches the ring depth, the requested row has been overwritten.
    logic [COORD_W-1:0] row_dist;

    always_comb begin
        row_dist = '0;
        if (wr_row >= mean_row) begin
            row_dist = wr_row - mean_row;
        end else begin
            row_dist = wr_row + HEIGHT - mean_row;
        end
    end

    // ---------------- S1 -> S2 threshold ----------------
    mean_req_t         s1_req;
    logic              s1_valid;
    logic signed [8:0] thr;
    logic              pix_gt;
    logic              fg;
    logic              hit;
    logic              is_end;

    always_comb begin
        thr    = $signed({1'b0, s1_req.mean}) - $signed({1'b0, C_OFFSET});
        pix_gt = $signed({1'b0, rd_data}) > thr;
        // A negative threshold means every pixel counts as foreground.
        fg     = thr[8] | pix_gt;
        hit    = fg ^ INVERT;
        is_end = (s1_req.row == END_ROW) && (s1_req.col == END_COL);
    end

    // ---------------- pipeline registers ----------------
    logic [COORD_W-1:0] fg_acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid       <= 1'b0;
            s1_req         <= '0;
            bin_valid      <= 1'b0;
            bin_out        <= '0;
            bin_row        <= '0;
            bin_col        <= '0;
            fg_count       <= '0;
            fg_count_valid <= 1'b0;
            fg_acc         <= '0;
            overrun        <= 1'b0;
        end else begin
            s1_valid       <= mean_valid;
            bin_valid      <= s1_valid;
            fg_count_valid <= 1'b0;

            if (mean_valid) begin
                s1_req.mean <= mean_in;
                s1_req.row  <= mean_row;
                s1_req.col  <= mean_col;
                if (row_dist >= RING) begin
                    overrun <= 1'b1;
                end
            end

            if (s1_valid) begin
                bin_out <= hit ? PIX_MAX : '0;
                bin_row <= s1_req.row;
                bin_col <= s1_req.col;
                if (is_end) begin
                    fg_count       <= fg_acc + {{(COORD_W-1){1'b0}}, hit};
                    fg_count_valid <= 1'b1;
                    fg_acc         <= '0;
                end else if (hit) begin
                    fg_acc <= fg_acc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adaptive_thresh_mean.sv
// tb/tb_adaptive_thresh_mean.sv - directed self-checking bench for adaptive_thresh_mean
module tb_adaptive_thresh_mean;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        gray_valid;
    logic [7:0]  gray;
    logic        mean_valid;
    logic [7:0]  mean_in;
    logic [31:0] mean_row;
    logic [31:0] mean_col;

    logic        bin_valid,  bin_valid_i;
    logic [7:0]  bin_out,    bin_out_i;
    logic [31:0] bin_row,    bin_row_i;
    logic [31:0] bin_col,    bin_col_i;
    logic [31:0] fg_count,   fg_count_i;
    logic        fg_count_valid, fg_count_valid_i;
    logic        overrun,    overrun_i;

    adaptive_thresh_mean #(.INVERT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .gray_valid(gray_valid), .gray(gray),
        .mean_valid(mean_valid), .mean_in(mean_in), .mean_row(mean_row), .mean_col(mean_col),
        .bin_valid(bin_valid), .bin_out(bin_out), .bin_row(bin_row), .bin_col(bin_col),
        .fg_count(fg_count), .fg_count_valid(fg_count_valid), .overrun(overrun)
    );

    adaptive_thresh_mean #(.INVERT(1'b1)) dut_inv (
        .clk(clk), .rst_n(rst_n), .gray_valid(gray_valid), .gray(gray),
        .mean_valid(mean_valid), .mean_in(mean_in), .mean_row(mean_row), .mean_col(mean_col),
        .bin_valid(bin_valid_i), .bin_out(bin_out_i), .bin_row(bin_row_i), .bin_col(bin_col_i),
        .fg_count(fg_count_i), .fg_count_valid(fg_count_valid_i), .overrun(overrun_i)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // frame-level observation counters
    int n_bin, n_bad, n_bad_i, n_pulse, n_pulse_i;
    logic [31:0] pulse_row, pulse_col;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        gray_valid = 1'b0;
        mean_valid = 1'b0;
    endtask

    task automatic clear_obs();
        n_bin = 0; n_bad = 0; n_bad_i = 0; n_pulse = 0; n_pulse_i = 0;
        pulse_row = '0; pulse_col = '0;
    endtask

    task automatic observe(input logic [7:0] exp_bin);
        if (bin_valid) begin
            n_bin++;
            if (bin_out !== exp_bin) n_bad++;
            if (bin_out_i !== ~exp_bin) n_bad_i++;
        end
        if (fg_count_valid) begin
            n_pulse++;
            pulse_row = bin_row;
            pulse_col = bin_col;
        end
        if (fg_count_valid_i) n_pulse_i++;
    endtask

    // One isolated mean request: checks the 2-cycle latency and the produced pixel.
    task automatic issue(input string tag, input int r, input int c, input logic [7:0] m,
                         input logic [7:0] exp, input logic [7:0] exp_i);
        gray_valid = 1'b0;
        mean_valid = 1'b1; mean_in = m; mean_row = r; mean_col = c;
        step();
        mean_valid = 1'b0;
        check({tag, "_lat1"}, bin_valid, 0);
        step();
        check({tag, "_valid"}, bin_valid, 1);
        check({tag, "_bin"}, bin_out, exp);
        check({tag, "_bin_inv"}, bin_out_i, exp_i);
        check({tag, "_row"}, bin_row, r);
        check({tag, "_col"}, bin_col, c);
    endtask

    int exp_col, seen, order_err, gaps;

    initial begin
        rst_n = 1'b0; idle(); gray = '0; mean_in = '0; mean_row = '0; mean_col = '0;
        step(); step();

        // reset state
        check("rst_bin_valid", bin_valid, 0);
        check("rst_bin_out", bin_out, 0);
        check("rst_fg_count", fg_count, 0);
        check("rst_fg_valid", fg_count_valid, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        step();

        // 1: flat frame, gray=100, mean=100 -> all 255, count 234*314
        clear_obs();
        for (int r = 0; r < 240; r++) begin
            for (int c = 0; c < 320; c++) begin
                gray_valid = 1'b1; gray = 8'd100;
                mean_valid = (r >= 6) && (c >= 6);
                mean_in = 8'd100; mean_row = r - 3; mean_col = c - 3;
                step();
                observe(8'd255);
            end
        end
        idle();
        repeat (3) begin
            step();
            observe(8'd255);
        end
        check("flat_bin_count", n_bin, 73476);
        check("flat_bad_pixels", n_bad, 0);
        check("flat_bad_pixels_inv", n_bad_i, 0);
        check("flat_pulses", n_pulse, 1);
        check("flat_fg_count", fg_count, 73476);
        check("flat_pulse_row", pulse_row, 236);
        check("flat_pulse_col", pulse_col, 316);
        check("flat_pulses_inv", n_pulse_i, 1);
        check("flat_fg_count_inv", fg_count_i, 0);
        check("flat_overrun", overrun, 0);

        // 2/3: rows 0..10 of a new frame, special pixels at (10,10..12)
        for (int r = 0; r <= 10; r++) begin
            for (int c = 0; c < 320; c++) begin
                if (r == 10 && c > 12) break;
                gray_valid = 1'b1;
                if (r == 10 && c == 10)      gray = 8'd90;
                else if (r == 10 && c == 11) gray = 8'd0;
                else                         gray = 8'd100;
                mean_valid = 1'b0;
                step();
            end
        end
        idle();
        issue("t2_dark", 10, 10, 8'd100, 8'd0, 8'd255);
        issue("t3_neg_thr", 10, 11, 8'd3, 8'd255, 8'd0);
        issue("t3_equal", 10, 12, 8'd105, 8'd0, 8'd255);
        issue("t3_above", 10, 12, 8'd104, 8'd255, 8'd0);

        // 4: 314 back-to-back means on row 10
        exp_col = 3; seen = 0; order_err = 0; gaps = 0;
        for (int k = 0; k < 316; k++) begin
            gray_valid = 1'b0;
            mean_valid = (k < 314); mean_in = 8'd50; mean_row = 10; mean_col = 3 + k;
            step();
            if (bin_valid) begin
                if (bin_col !== exp_col) order_err++;
                exp_col++;
                seen++;
            end else if (seen > 0 && seen < 314) begin
                gaps++;
            end
        end
        idle();
        check("b2b_count", seen, 314);
        check("b2b_order", order_err, 0);
        check("b2b_gaps", gaps, 0);

        // 5: advance writer to row 11, then probe distances 7 and 8
        for (int c = 13; c < 320; c++) begin
            gray_valid = 1'b1; gray = 8'd100; mean_valid = 1'b0;
            step();
        end
        idle();
        check("ovr_wr_row", dut.wr_row, 11);
        mean_valid = 1'b1; mean_in = 8'd100; mean_row = 4; mean_col = 0;
        step();
        idle();
        step();
        check("ovr_dist7", overrun, 0);
        mean_valid = 1'b1; mean_row = 3;
        step();
        idle();
        check("ovr_dist8", overrun, 1);
        check("ovr_dist8_inv", overrun_i, 1);
        repeat (5) step();
        check("ovr_sticky", overrun, 1);

        // 6: reset mid-frame with both streams active
        gray_valid = 1'b1; gray = 8'd100;
        mean_valid = 1'b1; mean_in = 8'd100; mean_row = 0; mean_col = 5;
        step(); step();
        rst_n = 1'b0;
        step();
        check("mrst_bin_valid", bin_valid, 0);
        check("mrst_bin_out", bin_out, 0);
        check("mrst_bin_row", bin_row, 0);
        check("mrst_bin_col", bin_col, 0);
        check("mrst_fg_count", fg_count, 0);
        check("mrst_fg_valid", fg_count_valid, 0);
        check("mrst_overrun", overrun, 0);
        check("mrst_wr_row", dut.wr_row, 0);
        check("mrst_wr_col", dut.wr_col, 0);
        rst_n = 1'b1;
        step();
        check("mrst_no_bin_after_release", bin_valid, 0);
        step();
        check("mrst_bin_resumes", bin_valid, 1);
        idle();
        clear_obs();
        repeat (10) begin
            step();
            observe(8'd255);
        end
        check("mrst_no_pulse", n_pulse, 0);
        check("mrst_overrun_clear", overrun, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
